// File: rtl/snake_pkg.sv
// Shared snake-game types: direction encoding and the reversal helper.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Opposite shares the axis bit and flips the sense bit.
  function automatic dir_t dir_opposite(dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/snake_dir_input_if.sv
// Button/strobe inputs and direction outputs of the direction-input conditioner.
interface snake_dir_input_if;

  logic             tick;
  logic             up_n;
  logic             down_n;
  logic             left;
  logic             right;
  logic             move_stb;
  snake_pkg::dir_t  dir;
  logic             dir_chg;
  logic             pending;
  logic [3:0]       btn_stable;

  modport master (
    output tick, up_n, down_n, left, right, move_stb,
    input  dir, dir_chg, pending, btn_stable
  );

  modport slave (
    input  tick, up_n, down_n, left, right, move_stb,
    output dir, dir_chg, pending, btn_stable
  );

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, tick-sampled debounce counter, registered press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic btn_i,
  output logic stable_o,
  output logic rise_o
);

  localparam logic [7:0] CntLast = 8'(DEBOUNCE_TICKS - 1);

  logic       sync1_q, sync2_q;
  logic       stable_q, stable_d;
  logic       rise_q;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = 8'd0;
    end else if (tick_i) begin
      if (cnt_q == CntLast) begin
        stable_d = ~stable_q;
        cnt_d    = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= 8'd0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= stable_d & ~stable_q;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;

endmodule

// File: rtl/snake_dir_input.sv
// Direction-input conditioner: debounced presses become legal turns, committed on move_stb.
module snake_dir_input
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input logic              CLK,
  input logic              RST,
  snake_dir_input_if.slave bus
);

  logic [3:0] raw, stable, rise;
  logic       req_valid;
  dir_t       req_dir, ref_dir;
  dir_t       dir_q, dir_d, pending_dir_q, pending_dir_d;
  logic       pending_q, pending_d, upd_q, dir_chg_q;

  // Bit order {right, left, down, up}, all active-high pressed.
  assign raw = {bus.right, bus.left, ~bus.down_n, ~bus.up_n};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_debounce (
      .clk_i   (CLK),
      .rst_i   (RST),
      .tick_i  (bus.tick),
      .btn_i   (raw[i]),
      .stable_o(stable[i]),
      .rise_o  (rise[i])
    );
  end

  always_comb begin
    req_valid = |rise;
    req_dir   = DIR_UP;
    if (rise[0])      req_dir = DIR_UP;
    else if (rise[1]) req_dir = DIR_DOWN;
    else if (rise[2]) req_dir = DIR_LEFT;
    else              req_dir = DIR_RIGHT;
  end

  always_comb begin
    dir_d         = dir_q;
    pending_d     = pending_q;
    pending_dir_d = pending_dir_q;
    // Commit first so a same-cycle press is judged against the new heading.
    if (bus.move_stb && pending_q) begin
      dir_d     = pending_dir_q;
      pending_d = 1'b0;
    end
    ref_dir = pending_d ? pending_dir_q : dir_d;
    if (req_valid && (req_dir != ref_dir) && (req_dir != dir_opposite(ref_dir))) begin
      pending_dir_d = req_dir;
      pending_d     = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dir_q         <= DIR_UP;
      pending_dir_q <= DIR_UP;
      pending_q     <= 1'b0;
      upd_q         <= 1'b0;
      dir_chg_q     <= 1'b0;
    end else begin
      dir_q         <= dir_d;
      pending_dir_q <= pending_dir_d;
      pending_q     <= pending_d;
      upd_q         <= (dir_d != dir_q);
      dir_chg_q     <= upd_q;
    end
  end

  assign bus.dir        = dir_q;
  assign bus.dir_chg    = dir_chg_q;
  assign bus.pending    = pending_q;
  assign bus.btn_stable = stable;

endmodule

// File: tb/tb_snake_dir_input.sv
// Directed bench for snake_dir_input with DEBOUNCE_TICKS = 20.
module tb_snake_dir_input;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int total = 0;
  int bad   = 0;

  snake_dir_input_if bus ();

  snake_dir_input #(
    .DEBOUNCE_TICKS(20)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // idx: 0 up, 1 down, 2 left, 3 right; val is "pressed".
  task automatic set_btn(input int idx, input logic val);
    case (idx)
      0: bus.up_n   = ~val;
      1: bus.down_n = ~val;
      2: bus.left   = val;
      default: bus.right = val;
    endcase
  endtask

  // Ends right after the clock edge that sampled the last tick.
  task automatic do_ticks(input int n);
    repeat (n) begin
      repeat (2) @(negedge CLK);
      bus.tick = 1'b1;
      @(negedge CLK);
      bus.tick = 1'b0;
    end
  endtask

  task automatic pulse_move();
    bus.move_stb = 1'b1;
    @(negedge CLK);
    bus.move_stb = 1'b0;
  endtask

  task automatic press_release(input int idx);
    set_btn(idx, 1'b1);
    repeat (2) @(negedge CLK);
    do_ticks(20);
    @(negedge CLK);
    set_btn(idx, 1'b0);
    repeat (2) @(negedge CLK);
    do_ticks(20);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    bus.tick = 1'b0; bus.up_n = 1'b1; bus.down_n = 1'b1;
    bus.left = 1'b0; bus.right = 1'b0; bus.move_stb = 1'b0;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.dir !== 2'd0) begin bad++; $display("FAIL reset_dir got=%0d exp=0", bus.dir); end
    total++; if (bus.pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b exp=0", bus.pending); end
    total++; if (bus.dir_chg !== 1'b0) begin bad++; $display("FAIL reset_dir_chg got=%b exp=0", bus.dir_chg); end
    total++; if (bus.btn_stable !== 4'b0000) begin bad++; $display("FAIL reset_stable got=%b exp=0000", bus.btn_stable); end
  endtask

  task automatic test_right_commit();
    set_btn(3, 1'b1);
    repeat (2) @(negedge CLK);
    do_ticks(19);
    total++; if (bus.btn_stable !== 4'b0000) begin bad++; $display("FAIL r_early_stable got=%b exp=0000", bus.btn_stable); end
    do_ticks(1);
    total++; if (bus.btn_stable !== 4'b1000) begin bad++; $display("FAIL r_stable got=%b exp=1000", bus.btn_stable); end
    total++; if (bus.pending !== 1'b0) begin bad++; $display("FAIL r_pending_early got=%b exp=0", bus.pending); end
    @(negedge CLK);
    total++; if (bus.pending !== 1'b1) begin bad++; $display("FAIL r_pending got=%b exp=1", bus.pending); end
    do_ticks(10);
    set_btn(3, 1'b0);
    repeat (2) @(negedge CLK);
    do_ticks(21);
    total++; if (bus.btn_stable !== 4'b0000) begin bad++; $display("FAIL r_release got=%b exp=0000", bus.btn_stable); end
    total++; if (bus.dir !== 2'd0) begin bad++; $display("FAIL r_dir_before got=%0d exp=0", bus.dir); end
    pulse_move();
    total++; if (bus.dir !== 2'd3) begin bad++; $display("FAIL r_dir got=%0d exp=3", bus.dir); end
    total++; if (bus.pending !== 1'b0) begin bad++; $display("FAIL r_pending_clr got=%b exp=0", bus.pending); end
    total++; if (bus.dir_chg !== 1'b0) begin bad++; $display("FAIL r_chg_early got=%b exp=0", bus.dir_chg); end
    @(negedge CLK);
    total++; if (bus.dir_chg !== 1'b1) begin bad++; $display("FAIL r_chg got=%b exp=1", bus.dir_chg); end
    @(negedge CLK);
    total++; if (bus.dir_chg !== 1'b0) begin bad++; $display("FAIL r_chg_width got=%b exp=0", bus.dir_chg); end
  endtask

  task automatic test_reject_reverse();
    do_reset();
    press_release(1);
    total++; if (bus.pending !== 1'b0) begin bad++; $display("FAIL rev_pending got=%b exp=0", bus.pending); end
    pulse_move();
    total++; if (bus.dir !== 2'd0) begin bad++; $display("FAIL rev_dir got=%0d exp=0", bus.dir); end
    @(negedge CLK);
    total++; if (bus.dir_chg !== 1'b0) begin bad++; $display("FAIL rev_chg got=%b exp=0", bus.dir_chg); end
  endtask

  task automatic test_glitch();
    set_btn(2, 1'b1);
    repeat (2) @(negedge CLK);
    do_ticks(15);
    set_btn(2, 1'b0);
    total++; if (bus.btn_stable !== 4'b0000) begin bad++; $display("FAIL gl_mid got=%b exp=0000", bus.btn_stable); end
    do_ticks(25);
    total++; if (bus.btn_stable !== 4'b0000) begin bad++; $display("FAIL gl_stable got=%b exp=0000", bus.btn_stable); end
    total++; if (bus.pending !== 1'b0) begin bad++; $display("FAIL gl_pending got=%b exp=0", bus.pending); end
  endtask

  task automatic test_double_tap();
    do_reset();
    press_release(2);
    total++; if (bus.pending !== 1'b1) begin bad++; $display("FAIL dt_pending got=%b exp=1", bus.pending); end
    press_release(3);
    total++; if (bus.pending !== 1'b1) begin bad++; $display("FAIL dt_pending2 got=%b exp=1", bus.pending); end
    pulse_move();
    total++; if (bus.dir !== 2'd2) begin bad++; $display("FAIL dt_dir got=%0d exp=2", bus.dir); end
  endtask

  task automatic test_priority();
    do_reset();
    press_release(3);
    pulse_move();
    total++; if (bus.dir !== 2'd3) begin bad++; $display("FAIL pr_setup got=%0d exp=3", bus.dir); end
    set_btn(0, 1'b1);
    set_btn(2, 1'b1);
    repeat (2) @(negedge CLK);
    do_ticks(20);
    total++; if (bus.btn_stable !== 4'b0101) begin bad++; $display("FAIL pr_stable got=%b exp=0101", bus.btn_stable); end
    @(negedge CLK);
    total++; if (bus.pending !== 1'b1) begin bad++; $display("FAIL pr_pending got=%b exp=1", bus.pending); end
    pulse_move();
    total++; if (bus.dir !== 2'd0) begin bad++; $display("FAIL pr_dir got=%0d exp=0", bus.dir); end
    set_btn(0, 1'b0);
    set_btn(2, 1'b0);
  endtask

  task automatic test_simultaneous_and_rst();
    do_reset();
    press_release(2);
    set_btn(1, 1'b1);
    repeat (2) @(negedge CLK);
    do_ticks(20);
    pulse_move();
    total++; if (bus.dir !== 2'd2) begin bad++; $display("FAIL sim_dir got=%0d exp=2", bus.dir); end
    total++; if (bus.pending !== 1'b1) begin bad++; $display("FAIL sim_pending got=%b exp=1", bus.pending); end
    set_btn(2, 1'b1);
    repeat (2) @(negedge CLK);
    do_ticks(8);
    #1 RST = 1'b1;
    #1;
    total++; if (bus.dir !== 2'd0) begin bad++; $display("FAIL rst_dir got=%0d exp=0", bus.dir); end
    total++; if (bus.pending !== 1'b0) begin bad++; $display("FAIL rst_pending got=%b exp=0", bus.pending); end
    total++; if (bus.btn_stable !== 4'b0000) begin bad++; $display("FAIL rst_stable got=%b exp=0000", bus.btn_stable); end
    set_btn(1, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    do_ticks(19);
    total++; if (bus.btn_stable !== 4'b0000) begin bad++; $display("FAIL rr_early got=%b exp=0000", bus.btn_stable); end
    do_ticks(1);
    total++; if (bus.btn_stable !== 4'b0100) begin bad++; $display("FAIL rr_stable got=%b exp=0100", bus.btn_stable); end
    @(negedge CLK);
    total++; if (bus.pending !== 1'b1) begin bad++; $display("FAIL rr_pending got=%b exp=1", bus.pending); end
    pulse_move();
    total++; if (bus.dir !== 2'd2) begin bad++; $display("FAIL rr_dir got=%0d exp=2", bus.dir); end
    set_btn(2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_right_commit();
    test_reject_reverse();
    test_glitch();
    test_double_tap();
    test_priority();
    test_simultaneous_and_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snake_dir_input.md
# snake_dir_input

Direction-input conditioner for the snake game. It sits between the four raw push-buttons and the game core. It synchronises and debounces each button and converts presses into direction requests. It rejects illegal requests, meaning a 180° reversal or a repeat of the current direction. It holds one pending request until the game core signals that the snake has moved, then commits it. This keeps the core's per-step direction stable, and fast double-taps between steps cannot reverse the snake into itself.

## Interface
Parameters:
- `DEBOUNCE_TICKS`, default 20: the number of consecutive `tick` samples a new raw level must persist before it is accepted (1..255).

Ports:
- `CLK`, in, 1: system clock. One clock; all state is on its rising edge.
- `RST`, in, 1: reset, asynchronous and active-high.
- `tick`, in, 1: 1 ms sampling strobe from the frequency divider, one `CLK` cycle wide.
- `up_n`, in, 1: raw up button, active-low.
- `down_n`, in, 1: raw down button, active-low.
- `left`, in, 1: raw left button, active-high.
- `right`, in, 1: raw right button, active-high.
- `move_stb`, in, 1: one-cycle strobe from the game core, asserted when the snake advances one cell.
- `dir`, out, 2: committed direction (0 = up, 1 = down, 2 = left, 3 = right).
- `dir_chg`, out, 1: one-cycle pulse in the cycle after `dir` changes.
- `pending`, out, 1: an accepted request is waiting for `move_stb`.
- `btn_stable`, out, 4: debounced pressed levels, active-high, ordered {right, left, down, up}.

## Operation
- Normalise: the active-low pins are inverted, so internally every button is active-high "pressed".
- Synchroniser: each button passes through a 2-FF synchroniser before any use.
- Debounce, per button, with an 8-bit counter `cnt` and a `stable` bit:
  - When the synced level equals `stable`, `cnt` is set to 0.
  - Otherwise `cnt` increments on each `tick`.
  - On the tick where `cnt` reaches `DEBOUNCE_TICKS-1`, `stable` toggles and `cnt` is set to 0.
  - Glitches shorter than `DEBOUNCE_TICKS` ticks are invisible.
- Press event: a registered rising edge of `stable`, one cycle wide.
- Priority: if several press events occur in the same cycle, only one is taken, in the order up > down > left > right.
- Acceptance: let `ref` be the direction the request is compared against.
  - `ref` is `pending_dir` if `pending` is high; otherwise it is `dir`.
  - A request `r` is accepted only if `r != ref` and `r != opposite(ref)`.
  - `opposite(d)` = {d[1], ~d[0]}.
  - An accepted request writes `pending_dir` and sets `pending`. A rejected request is dropped silently.
  - Because a pending turn is the comparison point, a second tap before the step either replaces the pending turn with a legal one or is dropped.
- Commit: on `move_stb` with `pending` high:
  - `dir` <= `pending_dir`.
  - `pending` <= 0.
  - `dir_chg` pulses in the next cycle.
  - A `move_stb` with `pending` low changes nothing.
- Simultaneous `move_stb` and press event: commit happens first. The press is then evaluated against the newly committed direction with `pending` treated as 0, and if accepted it becomes the new pending request in the same clock edge.
- `tick` and `move_stb` are independent; no ordering is required between them.

## Timing
- Reset values (asynchronous, effective immediately):
  - `dir` = 0 (up).
  - `pending` = 0, `dir_chg` = 0.
  - `btn_stable` = 4'b0000.
  - Synchroniser flops = released, all `cnt` = 0, press events = 0.
- Latency from pin edge to `pending` high:
  - 2 cycles for synchronisation.
  - Plus `DEBOUNCE_TICKS` ticks.
  - Plus 1 cycle for `stable` to register.
  - Plus 1 cycle for the edge/accept stage.
- Latency from `move_stb` to `dir` update: 1 cycle. `dir_chg` follows 1 cycle after that.
- Button held down: exactly one press event. Release generates no event.
- `RST` asserted mid-debounce or mid-pending: everything returns to the reset values. A button still held when `RST` deasserts is re-debounced and produces one press event.
- `cnt` saturation: cannot occur, because the counter is cleared on the toggle.

## Structure
- Shared package `snake_pkg`:
  - `dir_t` enum (`DIR_UP`, `DIR_DOWN`, `DIR_LEFT`, `DIR_RIGHT` = 0..3).
  - Function `dir_opposite`.
  - Shared with the game core and scoring logic.
- Sub-module `btn_debounce` (synchroniser + counter + `stable` + rise pulse), parameterised by `DEBOUNCE_TICKS`, instantiated four times.
- The top level holds the priority, acceptance and commit logic.

## Test plan
- Reset, then press `right` (held 30 ticks) -> `pending`=1 after 2 + 20 ticks + 2 cycles. Then `move_stb` -> `dir`=3 next cycle, `dir_chg` pulse one cycle later, `pending`=0.
- `dir`=0 (up): press `down_n` (low) -> rejected, `pending` stays 0. Then `move_stb` -> `dir` stays 0, no `dir_chg`.
- Glitch: `left` high for 15 ticks, then low -> `btn_stable[2]` never rises, no request.
- `dir`=0: press `left`, then `right` before any `move_stb` -> `right` is rejected (opposite of pending `left`), `pending_dir` stays 2. `move_stb` -> `dir`=2.
- Same-cycle `up` and `left` press events with `dir`=3 (right) -> `up` wins, `pending_dir`=0.
- `pending`=1 (left) with `dir`=0, and a `down` press event in the same cycle as `move_stb` -> `dir`=2, then `down` is accepted as the new pending request (`pending`=1, `pending_dir`=1). Assert `RST` mid-debounce -> all outputs return to reset values within the same cycle.
